// File: rtl/pci_bus_pkg.sv
// Shared definitions for the PCI bus arbiter: FSM state encoding,
// active-low bus line levels and the default grant timeout.
package pci_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  // Levels for the shared active-low frame/irdy lines.
  localparam logic BUS_ASSERT   = 1'b0;
  localparam logic BUS_DEASSERT = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin selector.
// Ports: req    - request vector, one bit per device
//        last   - index of the previous owner; search starts just above it
//        winner - first requesting index found, wrapping modulo NUM_DEV
//        valid  - high when any request bit is set
module pci_rr_picker #(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned IDXW    = 2
) (
  input  logic [NUM_DEV-1:0] req,
  input  logic [IDXW-1:0]    last,
  output logic [IDXW-1:0]    winner,
  output logic               valid
);

  // Walk last+1 .. last+NUM_DEV; the last step lands on the owner itself,
  // so a lone requester can win again.
  always_comb begin
    int unsigned j;
    logic [IDXW-1:0] idx;
    winner = last;
    valid  = 1'b0;
    j      = 0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_DEV; i++) begin
      j   = (32'(last) + i) % NUM_DEV;
      idx = IDXW'(j);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter with idle-bus regrant and grant timeout.
// Ports: clk, rst  - bus clock, synchronous active-high reset
//        req       - per-device requests (active-high)
//        frame     - shared frame (active-low)
//        irdy      - shared initiator ready (active-low)
//        gnt       - one-hot registered grants
//        owner     - current or most recent grantee index
//        bus_busy  - high while the owner runs a transaction
//        timeout   - one-cycle pulse when an unused grant is revoked
module pci_bus_arbiter
  import pci_bus_pkg::*;
#(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned IDXW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DEV-1:0] req,
  input  logic               frame,
  input  logic               irdy,
  output logic [NUM_DEV-1:0] gnt,
  output logic [IDXW-1:0]    owner,
  output logic               bus_busy,
  output logic               timeout
);

  localparam int unsigned   TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  state_t          state;
  logic [TW-1:0]   timer;
  logic [IDXW-1:0] pick_idx;
  logic            pick_valid;
  logic            bus_idle;
  logic            req_owner;

  assign bus_idle  = (frame == BUS_DEASSERT) && (irdy == BUS_DEASSERT);
  assign req_owner = req[owner];

  pci_rr_picker #(
    .NUM_DEV (NUM_DEV),
    .IDXW    (IDXW)
  ) u_picker (
    .req    (req),
    .last   (owner),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      owner    <= IDXW'(NUM_DEV - 1);
      bus_busy <= 1'b0;
      timeout  <= 1'b0;
      timer    <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_valid && bus_idle) begin
            gnt   <= NUM_DEV'(1) << pick_idx;
            owner <= pick_idx;
            timer <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A dropped request outranks a simultaneous frame assertion.
          if (!req_owner) begin
            gnt   <= '0;
            state <= ST_TURN;
          end else if (frame == BUS_ASSERT) begin
            bus_busy <= 1'b1;
            state    <= ST_BUSY;
          end else if (timer == TIMER_MAX) begin
            gnt     <= '0;
            timeout <= 1'b1;
            state   <= ST_TURN;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_BUSY: begin
          if (!req_owner) begin
            gnt      <= '0;
            bus_busy <= 1'b0;
            state    <= ST_TURN;
          end
        end
        ST_TURN: begin
          if (bus_idle) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule
